ps2_key_receiver: RTL and testbench

PS/2 keyboard receiver for the breadboard pong build. It samples the keyboard-driven ps2_clk/ps2_data lines and deframes 11-bit device-to-host frames into scan codes. It tracks make/break/extended prefixes and produces level "key held" flags for both players' four directions. These flags drive the paddle-movement inputs of the VGA controller, so players can use a keyboard instead of board buttons.

---
 rtl/ps2_key_receiver.sv | 174 +++++++++++++++++
 tb/tb_ps2_key_receiver.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: conditions ps2_clk/ps2_data, deframes 11-bit frames and keeps key-held flags.
// Optional build macro PS2_PARITY_CHECK_EN rejects frames with bad odd parity.
module ps2_key_receiver #(
  parameter int         FILTER_LEN     = 8,
  parameter int         TIMEOUT_CYCLES = 200000,
  parameter logic [7:0] P1_UP_CODE     = 8'h1D,
  parameter logic [7:0] P1_DOWN_CODE   = 8'h1B,
  parameter logic [7:0] P1_LEFT_CODE   = 8'h1C,
  parameter logic [7:0] P1_RIGHT_CODE  = 8'h23,
  parameter logic [7:0] P2_UP_CODE     = 8'h75,
  parameter logic [7:0] P2_DOWN_CODE   = 8'h72,
  parameter logic [7:0] P2_LEFT_CODE   = 8'h6B,
  parameter logic [7:0] P2_RIGHT_CODE  = 8'h74
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       frame_err,
  output logic       p1_up,
  output logic       p1_down,
  output logic       p1_left,
  output logic       p1_right,
  output logic       p2_up,
  output logic       p2_down,
  output logic       p2_left,
  output logic       p2_right
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t          state, next_state;
  logic            clk_s1, clk_s2, data_s1, data_s2;
  logic            filt;
  logic [FW-1:0]   filt_cnt;
  logic            fall;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift_reg;
  logic            par_bit;
  logic [TW-1:0]   tmo_cnt;
  logic            timeout;
  logic            par_ok;
  logic            load_code;
  logic            err_now;
  logic            brk_pending, ext_pending;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
      filt     <= 1'b1;
      filt_cnt <= FW'(FILTER_LEN - 1);
      fall     <= 1'b0;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
      fall    <= 1'b0;
      if (clk_s2 == filt) begin
        filt_cnt <= FW'(FILTER_LEN - 1);
      end else if (filt_cnt == '0) begin
        // FILTER_LEN consecutive differing samples: accept the new level
        filt     <= clk_s2;
        filt_cnt <= FW'(FILTER_LEN - 1);
        fall     <= filt & ~clk_s2;
      end else begin
        filt_cnt <= filt_cnt - 1'b1;
      end
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  assign par_ok = ^{shift_reg, par_bit};
`else
  // parity bit is captured but never gates acceptance
  assign par_ok = (^{shift_reg, par_bit}) | 1'b1;
`endif

  assign timeout = (state != IDLE) && !fall && (tmo_cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    load_code  = 1'b0;
    err_now    = 1'b0;
    if (fall) begin
      case (state)
        IDLE:   if (!data_s2) next_state = DATA;
        DATA:   if (bit_cnt == 3'd7) next_state = PARITY;
        PARITY: next_state = STOP;
        STOP: begin
          next_state = IDLE;
          if (data_s2 && par_ok) load_code = 1'b1;
          else                   err_now   = 1'b1;
        end
        default: next_state = IDLE;
      endcase
    end else if (timeout) begin
      next_state = IDLE;
      err_now    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt    <= '0;
      shift_reg  <= '0;
      par_bit    <= 1'b0;
      tmo_cnt    <= '0;
      scan_code  <= '0;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      code_valid <= load_code;
      frame_err  <= err_now;
      if (load_code) scan_code <= shift_reg;
      if (fall || state == IDLE) tmo_cnt <= TW'(TIMEOUT_CYCLES);
      else if (tmo_cnt != '0)    tmo_cnt <= tmo_cnt - 1'b1;
      if (fall) begin
        case (state)
          IDLE:   bit_cnt <= '0;
          DATA: begin
            shift_reg <= {data_s2, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 1'b1;
          end
          PARITY: par_bit <= data_s2;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      brk_pending <= 1'b0;
      ext_pending <= 1'b0;
      {p1_up, p1_down, p1_left, p1_right} <= '0;
      {p2_up, p2_down, p2_left, p2_right} <= '0;
    end else if (code_valid) begin
      if (scan_code == 8'hF0) begin
        brk_pending <= 1'b1;
      end else if (scan_code == 8'hE0) begin
        ext_pending <= 1'b1;
      end else begin
        brk_pending <= 1'b0;
        ext_pending <= 1'b0;
        if (ext_pending) begin
          if (scan_code == P2_UP_CODE)    p2_up    <= !brk_pending;
          if (scan_code == P2_DOWN_CODE)  p2_down  <= !brk_pending;
          if (scan_code == P2_LEFT_CODE)  p2_left  <= !brk_pending;
          if (scan_code == P2_RIGHT_CODE) p2_right <= !brk_pending;
        end else begin
          if (scan_code == P1_UP_CODE)    p1_up    <= !brk_pending;
          if (scan_code == P1_DOWN_CODE)  p1_down  <= !brk_pending;
          if (scan_code == P1_LEFT_CODE)  p1_left  <= !brk_pending;
          if (scan_code == P1_RIGHT_CODE) p1_right <= !brk_pending;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Directed bench for ps2_key_receiver with shortened PS/2 bit period and timeout.
module tb_ps2_key_receiver;

  localparam int HALF = 50;
  localparam int TMO  = 2000;

  localparam logic [7:0] F_P1U = 8'h80, F_P1D = 8'h40, F_P1L = 8'h20, F_P1R = 8'h10;
  localparam logic [7:0] F_P2U = 8'h08, F_P2L = 8'h02;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] scan_code;
  logic       code_valid, frame_err;
  logic       p1_up, p1_down, p1_left, p1_right;
  logic       p2_up, p2_down, p2_left, p2_right;
  logic [7:0] flags;

  int errors = 0;
  int checks = 0;
  int n_valid = 0;
  int n_err = 0;

  ps2_key_receiver #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .scan_code(scan_code), .code_valid(code_valid), .frame_err(frame_err),
    .p1_up(p1_up), .p1_down(p1_down), .p1_left(p1_left), .p1_right(p1_right),
    .p2_up(p2_up), .p2_down(p2_down), .p2_left(p2_left), .p2_right(p2_right)
  );

  assign flags = {p1_up, p1_down, p1_left, p1_right, p2_up, p2_down, p2_left, p2_right};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (code_valid) n_valid++;
    if (frame_err)  n_err++;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input logic glitch);
    ps2_data = b;
    if (glitch) begin
      cyc(HALF / 2);
      ps2_clk = 1'b0;
      cyc(3);
      ps2_clk = 1'b1;
      cyc(HALF - HALF / 2 - 3);
    end else begin
      cyc(HALF);
    end
    ps2_clk = 1'b0;
    cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop,
                            input int glitch_bit);
    logic [10:0] bits;
    bits = {stop, (~^d) ^ par_flip, d, 1'b0};
    for (int i = 0; i < 11; i++) drive_bit(bits[i], i == glitch_bit);
    ps2_data = 1'b1;
    cyc(HALF);
  endtask

  task automatic send(input logic [7:0] d);
    send_frame(d, 1'b0, 1'b1, -1);
  endtask

  initial begin
    int v0, e0, elapsed;
    logic found;
    logic [10:0] bits;

    cyc(3);
    chk("rst_flags", 32'(flags), 32'h0);
    chk("rst_code", 32'(scan_code), 32'h0);
    chk("rst_valid", 32'(code_valid), 32'h0);
    chk("rst_err", 32'(frame_err), 32'h0);
    reset = 1'b1;
    cyc(20);

    // 1D make with cycle-level latency check around the stop strobe
    v0 = n_valid;
    bits = {1'b1, ~^8'h1D, 8'h1D, 1'b0};
    for (int i = 0; i < 10; i++) drive_bit(bits[i], 1'b0);
    ps2_data = 1'b1;
    cyc(HALF);
    ps2_clk = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      cyc(1);
      if (code_valid) found = 1'b1;
    end
    chk("cv_seen", 32'(found), 32'h1);
    chk("cv_code", 32'(scan_code), 32'h1D);
    chk("flag_not_yet", 32'(flags), 32'h0);
    cyc(1);
    chk("flag_p1u_lat", 32'(flags), 32'(F_P1U));
    chk("cv_one_cycle", 32'(code_valid), 32'h0);
    cyc(HALF);
    ps2_clk = 1'b1;
    cyc(HALF);
    chk("cv_count1", 32'(n_valid - v0), 32'h1);

    send(8'hF0); send(8'h1D);
    chk("p1u_break", 32'(flags), 32'h0);

    send(8'hE0); send(8'h75);
    chk("p2u_make", 32'(flags), 32'(F_P2U));
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("p2u_break", 32'(flags), 32'h0);
    send(8'h75);
    chk("75_noext", 32'(flags), 32'h0);
    send(8'hE0); send(8'h1D);
    chk("e0_1d", 32'(flags), 32'h0);

    send(8'h1D); send(8'h23);
    chk("w_d_held", 32'(flags), 32'(F_P1U | F_P1R));
    send(8'hF0); send(8'h1D);
    chk("w_released", 32'(flags), 32'(F_P1R));
    for (int i = 0; i < 3; i++) begin
      send(8'h1D);
      chk("typematic", 32'(flags), 32'(F_P1U | F_P1R));
    end

    // partial frame then timeout
    v0 = n_valid; e0 = n_err;
    bits = {1'b1, ~^8'h55, 8'h55, 1'b0};
    for (int i = 0; i < 5; i++) drive_bit(bits[i], 1'b0);
    ps2_data = 1'b1;
    elapsed = 0;
    found = 1'b0;
    while (!found && elapsed < 3000) begin
      cyc(1);
      elapsed++;
      if (frame_err) found = 1'b1;
    end
    chk("tmo_seen", 32'(found), 32'h1);
    chk("tmo_window", 32'((elapsed >= TMO - HALF) && (elapsed <= TMO - HALF + 30)), 32'h1);
    cyc(2500 - elapsed);
    chk("tmo_err_cnt", 32'(n_err - e0), 32'h1);
    chk("tmo_no_valid", 32'(n_valid - v0), 32'h0);
    send(8'h1B);
    chk("after_tmo_1b", 32'(flags), 32'(F_P1U | F_P1D | F_P1R));

    send(8'hF0); send(8'h1D);
    chk("p1u_clear", 32'(flags), 32'(F_P1D | F_P1R));
    v0 = n_valid; e0 = n_err;
    send_frame(8'h1D, 1'b0, 1'b0, -1);
    chk("stop0_err", 32'(n_err - e0), 32'h1);
    chk("stop0_valid", 32'(n_valid - v0), 32'h0);
    chk("stop0_flags", 32'(flags), 32'(F_P1D | F_P1R));

    v0 = n_valid; e0 = n_err;
    send_frame(8'h1D, 1'b1, 1'b1, -1);
`ifdef PS2_PARITY_CHECK_EN
    chk("par_err", 32'(n_err - e0), 32'h1);
    chk("par_valid", 32'(n_valid - v0), 32'h0);
    chk("par_flags", 32'(flags), 32'(F_P1D | F_P1R));
`else
    chk("par_err", 32'(n_err - e0), 32'h0);
    chk("par_valid", 32'(n_valid - v0), 32'h1);
    chk("par_flags", 32'(flags), 32'(F_P1U | F_P1D | F_P1R));
`endif

    // glitches on ps2_clk must not create strobes
    v0 = n_valid; e0 = n_err;
    send_frame(8'hE0, 1'b0, 1'b1, 2);
    send_frame(8'h6B, 1'b0, 1'b1, 4);
    chk("glitch_valid", 32'(n_valid - v0), 32'h2);
    chk("glitch_err", 32'(n_err - e0), 32'h0);
    chk("glitch_code", 32'(scan_code), 32'h6B);
    chk("glitch_p2l", 32'(32'(flags) & 32'(F_P2L)), 32'(F_P2L));

    // reset during bit 5 of a frame
    bits = {1'b1, ~^8'h23, 8'h23, 1'b0};
    for (int i = 0; i < 6; i++) drive_bit(bits[i], 1'b0);
    ps2_data = bits[6];
    cyc(HALF / 2);
    reset = 1'b0;
    #1;
    chk("mid_rst_flags", 32'(flags), 32'h0);
    chk("mid_rst_code", 32'(scan_code), 32'h0);
    chk("mid_rst_pulses", 32'({code_valid, frame_err}), 32'h0);
    cyc(5);
    reset = 1'b1;
    ps2_data = 1'b1;
    cyc(HALF);
    send(8'h1C);
    chk("post_rst_code", 32'(scan_code), 32'h1C);
    chk("post_rst_flags", 32'(flags), 32'(F_P1L));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
